dest_tag_pipeline: RTL and testbench
====================================

Name: dest_tag_pipeline

Overview:
- Writer side of the operand-forwarding check: carries each issued instruction's destination tag, write-enable and load flag down the EX, MEM and WB stages.
- Presents those per-stage tags to the forwarding comparators.
- Consumes the returned load-use stall: inserts a bubble into EX and holds ID.
- Handles data-memory hold, branch flush, protocol-error flags and saturating stall/bubble counters.

Parameters:
- TAG_W, 4, register tag width (r0..r15)
- CNT_W, 16, width of performance counters

Ports:
- clk  input  1  core clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- id_valid  input  1  ID holds a real instruction
- id_dst  input  TAG_W  destination tag of the ID instruction
- id_wr  input  1  ID instruction writes its destination
- id_load  input  1  ID instruction is a load
- stall_in  input  1  load-use stall from the forwarding check
- flush  input  1  branch taken in EX; kill the ID instruction
- mem_hold  input  1  data memory not ready; freeze all stages
- id_ready  output  1  ID may advance this cycle
- ex_dst / ex_wr / ex_load  output  TAG_W/1/1  EX-stage tag set (match slot 1, load flag)
- mem_dst / mem_wr  output  TAG_W/1  MEM-stage tag set (match slot 2)
- wb_dst / wb_wr  output  TAG_W/1  WB-stage tag set (match slot 3)
- err_stall  output  1  sticky: illegal stall seen
- stall_cnt  output  CNT_W  load-use stall cycles, saturating
- bubble_cnt  output  CNT_W  bubbles inserted into EX, saturating

Behaviour:
- Reset (async, rst_n=0):
  - All dst fields = 0; all wr/load flags = 0.
  - Counters = 0; err_stall = 0; FSM = RUN; flush_pend = 0.
  - Release is synchronous to clk.
- Bubble = {dst=0, wr=0, load=0}.
- Advance cycle (mem_hold=0):
  - WB <= MEM.
  - MEM <= EX.
  - EX <= bubble if stall_in | flush | flush_pend | !id_valid; otherwise {id_dst, id_wr, id_load}.
- Hold cycle (mem_hold=1):
  - Every stage register is unchanged.
  - A flush seen during hold sets flush_pend.
  - flush_pend clears on the next advance cycle, after being applied.
- id_ready = !mem_hold & !stall_in, combinational.
- Latency: a tag presented with id_ready=1 appears on ex_* 1 cycle later, mem_* 2 cycles later, wb_* 3 cycles later, excluding hold cycles.
- FSM states: RUN, LU_STALL, HOLD.
  - RUN -> HOLD on mem_hold.
  - RUN -> LU_STALL on stall_in & !mem_hold.
  - LU_STALL -> RUN when stall_in=0 and mem_hold=0.
  - LU_STALL -> HOLD on mem_hold.
  - HOLD -> RUN when mem_hold drops. The stall is re-evaluated on that edge.
  - mem_hold has priority over stall_in and flush.
- err_stall sets (sticky until reset) when either:
  - stall_in=1 in RUN while ex_load=0, or ex_wr=0 (stall without a load in EX); or
  - stall_in=1 on a second consecutive cycle while in LU_STALL (the load has already moved to MEM).
- Counters:
  - stall_cnt increments on every cycle with stall_in & !mem_hold.
  - bubble_cnt increments on every advance cycle in which EX loads a bubble, for any cause.
  - Both saturate at all-ones and do not wrap.
- Simultaneous stall_in and flush: a single bubble is inserted and bubble_cnt increments once.
- Reset mid-hold or mid-stall: all state clears immediately; no pending flush survives.

Decomposition:
- Shared package (pipeline package):
  - TAG_W
  - stage-tag struct {dst, wr, load}
  - BUBBLE constant
  - FSM state enum
- One natural sub-module: sat_counter (parameterised CNT_W, inc input), instantiated twice.
- Stage registers and the FSM stay in the top module.

Test Plan:
- Reset/pipe flow: release rst_n, issue r3 wr=1 then r5 wr=1, no stalls. Required: ex_dst=3 at cycle 1, mem_dst=3 and ex_dst=5 at cycle 2, wb_dst=3 at cycle 3; all wr flags high in step.
- Load-use: load r2 (id_load=1) then stall_in=1 for one cycle with ex_load=1. Required:
  - id_ready=0 during the stall;
  - EX gets a bubble (ex_wr=0) next cycle while mem_dst=2;
  - stall_cnt=1, bubble_cnt=1, err_stall=0.
- Memory hold: assert mem_hold for 3 cycles with r7 in EX, and pulse flush during the hold. Required:
  - all tags frozen for 3 cycles;
  - on release, r7 moves to MEM and EX receives a bubble from flush_pend;
  - bubble_cnt +1.
- Illegal stall: stall_in=1 with ex_load=0, and separately stall_in held 2 cycles after a load. Required: err_stall=1 and it stays 1 until rst_n.
- Saturation: CNT_W=3, hold stall_in=1 (ex_load=1) for 10 cycles. Required: stall_cnt stops at 7 with no wrap.
- Async reset mid-stall: drop rst_n between clock edges. Required: all outputs 0 immediately and FSM in RUN after release.

Source files
------------

// File: rtl/dest_tag_pipeline_pkg.sv
// Shared types for the destination-tag pipeline: the per-stage tag record,
// the bubble value, and the stall/hold FSM states.
package dest_tag_pipeline_pkg;

    localparam int TAG_W = 4;

    typedef struct packed {
        logic [TAG_W-1:0] dst;
        logic             wr;
        logic             load;
    } stage_t;

    localparam stage_t BUBBLE = '{dst: '0, wr: 1'b0, load: 1'b0};

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        HOLD     = 2'd2
    } state_t;

endpackage

// File: rtl/dest_tag_pipeline_sat_counter.sv
// Saturating up-counter: it counts up by one on each cycle with inc high
// and holds at all-ones.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/dest_tag_pipeline.sv
// Carries destination tags down EX/MEM/WB for the forwarding comparators and
// inserts EX bubbles for load-use stalls, flushes and empty ID slots.
module dest_tag_pipeline
    import dest_tag_pipeline_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [TAG_W-1:0] id_dst,
    input  logic             id_wr,
    input  logic             id_load,
    input  logic             stall_in,
    input  logic             flush,
    input  logic             mem_hold,
    output logic             id_ready,
    output logic [TAG_W-1:0] ex_dst,
    output logic             ex_wr,
    output logic             ex_load,
    output logic [TAG_W-1:0] mem_dst,
    output logic             mem_wr,
    output logic [TAG_W-1:0] wb_dst,
    output logic             wb_wr,
    output logic             err_stall,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] bubble_cnt
);

    state_t state, state_nxt;
    stage_t ex_q, mem_q, wb_q;
    logic   flush_pend;
    logic   advance;
    logic   ex_bubble;
    logic   err_set;

    assign advance   = !mem_hold;
    assign ex_bubble = stall_in | flush | flush_pend | !id_valid;
    assign id_ready  = !mem_hold & !stall_in;

    // A stall is legal only on the first cycle and only with a writing load in EX.
    assign err_set = stall_in &
                     (((state == RUN) & (!ex_q.load | !ex_q.wr)) | (state == LU_STALL));

    // NOTE: sequential state uses non-blocking assignments so all stages
    // sample their predecessors' pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q       <= BUBBLE;
            mem_q      <= BUBBLE;
            wb_q       <= BUBBLE;
            flush_pend <= 1'b0;
            err_stall  <= 1'b0;
            state      <= RUN;
        end else begin
            state <= state_nxt;
            if (err_set) begin
                err_stall <= 1'b1;
            end
            if (advance) begin
                wb_q       <= mem_q;
                mem_q      <= ex_q;
                ex_q       <= ex_bubble ? BUBBLE : '{dst: id_dst, wr: id_wr, load: id_load};
                flush_pend <= 1'b0;
            end else if (flush) begin
                flush_pend <= 1'b1;
            end
        end
    end

    // NOTE: next-state gets a default before the case so no latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            RUN:      if (mem_hold) state_nxt = HOLD;
                      else if (stall_in) state_nxt = LU_STALL;
            LU_STALL: if (mem_hold) state_nxt = HOLD;
                      else if (!stall_in) state_nxt = RUN;
            HOLD:     if (!mem_hold) state_nxt = stall_in ? LU_STALL : RUN;
            default:  state_nxt = RUN;
        endcase
    end

    assign ex_dst  = ex_q.dst;
    assign ex_wr   = ex_q.wr;
    assign ex_load = ex_q.load;
    assign mem_dst = mem_q.dst;
    assign mem_wr  = mem_q.wr;
    assign wb_dst  = wb_q.dst;
    assign wb_wr   = wb_q.wr;

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (stall_in & advance),
        .count (stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (advance & ex_bubble),
        .count (bubble_cnt)
    );

endmodule

// File: tb/tb_dest_tag_pipeline.sv
// Directed bench for dest_tag_pipeline: a vector table for pipe flow, load-use,
// hold and flush, plus hand sequences for illegal stalls, saturation and async reset.
module tb_dest_tag_pipeline;

    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          id_valid = 1'b0;
    logic [3:0]    id_dst = '0;
    logic          id_wr = 1'b0;
    logic          id_load = 1'b0;
    logic          stall_in = 1'b0;
    logic          flush = 1'b0;
    logic          mem_hold = 1'b0;
    logic          id_ready;
    logic [3:0]    ex_dst, mem_dst, wb_dst;
    logic          ex_wr, ex_load, mem_wr, wb_wr;
    logic          err_stall;
    logic [CW-1:0] stall_cnt, bubble_cnt;

    int total = 0;
    int bad   = 0;

    dest_tag_pipeline #(.CNT_W(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .id_valid   (id_valid),
        .id_dst     (id_dst),
        .id_wr      (id_wr),
        .id_load    (id_load),
        .stall_in   (stall_in),
        .flush      (flush),
        .mem_hold   (mem_hold),
        .id_ready   (id_ready),
        .ex_dst     (ex_dst),
        .ex_wr      (ex_wr),
        .ex_load    (ex_load),
        .mem_dst    (mem_dst),
        .mem_wr     (mem_wr),
        .wb_dst     (wb_dst),
        .wb_wr      (wb_wr),
        .err_stall  (err_stall),
        .stall_cnt  (stall_cnt),
        .bubble_cnt (bubble_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       v, w, l, s, f, h;
        logic [3:0] d;
        logic       rdy;
        logic [3:0] exd;
        logic       exw, exl;
        logic [3:0] md;
        logic       mw;
        logic [3:0] wd;
        logic       ww, err;
        int         sc, bc;
    } vec_t;

    function automatic vec_t mk(logic v, logic [3:0] d, logic w, logic l, logic s, logic f,
                                logic h, logic rdy, logic [3:0] exd, logic exw, logic exl,
                                logic [3:0] md, logic mw, logic [3:0] wd, logic ww,
                                logic err, int sc, int bc);
        vec_t r;
        r.v = v; r.d = d; r.w = w; r.l = l; r.s = s; r.f = f; r.h = h;
        r.rdy = rdy; r.exd = exd; r.exw = exw; r.exl = exl; r.md = md; r.mw = mw;
        r.wd = wd; r.ww = ww; r.err = err; r.sc = sc; r.bc = bc;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [3:0] d, input logic w, input logic l,
                         input logic s, input logic f, input logic h);
        id_valid = v; id_dst = d; id_wr = w; id_load = l;
        stall_in = s; flush = f; mem_hold = h;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
    endtask

    vec_t tbl[16];

    initial begin
        //           v  d  w  l  s  f  h  rdy exd w  l  md w  wd w  err sc bc
        tbl[0]  = mk(1, 3, 1, 0, 0, 0, 0, 1,  3, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[1]  = mk(1, 5, 1, 0, 0, 0, 0, 1,  5, 1, 0, 3, 1, 0, 0, 0, 0, 0);
        tbl[2]  = mk(1, 2, 1, 1, 0, 0, 0, 1,  2, 1, 1, 5, 1, 3, 1, 0, 0, 0);
        tbl[3]  = mk(1, 4, 1, 0, 1, 0, 0, 0,  0, 0, 0, 2, 1, 5, 1, 0, 1, 1);
        tbl[4]  = mk(1, 4, 1, 0, 0, 0, 0, 1,  4, 1, 0, 0, 0, 2, 1, 0, 1, 1);
        tbl[5]  = mk(1, 7, 1, 0, 0, 0, 0, 1,  7, 1, 0, 4, 1, 0, 0, 0, 1, 1);
        tbl[6]  = mk(1, 9, 1, 0, 0, 0, 1, 0,  7, 1, 0, 4, 1, 0, 0, 0, 1, 1);
        tbl[7]  = mk(1, 9, 1, 0, 0, 1, 1, 0,  7, 1, 0, 4, 1, 0, 0, 0, 1, 1);
        tbl[8]  = mk(1, 9, 1, 0, 0, 0, 1, 0,  7, 1, 0, 4, 1, 0, 0, 0, 1, 1);
        tbl[9]  = mk(1, 9, 1, 1, 0, 0, 0, 1,  0, 0, 0, 7, 1, 4, 1, 0, 1, 2);
        tbl[10] = mk(1, 9, 1, 1, 0, 0, 0, 1,  9, 1, 1, 0, 0, 7, 1, 0, 1, 2);
        tbl[11] = mk(1, 6, 1, 0, 1, 1, 0, 0,  0, 0, 0, 9, 1, 0, 0, 0, 2, 3);
        tbl[12] = mk(0, 6, 1, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 9, 1, 0, 2, 4);
        tbl[13] = mk(1, 1, 1, 0, 0, 0, 0, 1,  1, 1, 0, 0, 0, 0, 0, 0, 2, 4);
        tbl[14] = mk(1, 8, 1, 0, 0, 1, 0, 1,  0, 0, 0, 1, 1, 0, 0, 0, 2, 5);
        tbl[15] = mk(1, 8, 1, 0, 0, 0, 0, 1,  8, 1, 0, 0, 0, 1, 1, 0, 2, 5);

        // Reset state while rst_n is low.
        drive(1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        check("reset stages", {ex_dst, ex_wr, ex_load, mem_dst, mem_wr, wb_dst, wb_wr}, 0);
        check("reset err", err_stall, 0);
        check("reset counters", {stall_cnt, bubble_cnt}, 0);
        do_reset();

        for (int i = 0; i < 16; i++) begin
            drive(tbl[i].v, tbl[i].d, tbl[i].w, tbl[i].l, tbl[i].s, tbl[i].f, tbl[i].h);
            #1;
            check($sformatf("v%0d id_ready", i), id_ready, tbl[i].rdy);
            tick();
            check($sformatf("v%0d ex_dst", i), ex_dst, tbl[i].exd);
            check($sformatf("v%0d ex_wr", i), ex_wr, tbl[i].exw);
            check($sformatf("v%0d ex_load", i), ex_load, tbl[i].exl);
            check($sformatf("v%0d mem_dst", i), mem_dst, tbl[i].md);
            check($sformatf("v%0d mem_wr", i), mem_wr, tbl[i].mw);
            check($sformatf("v%0d wb_dst", i), wb_dst, tbl[i].wd);
            check($sformatf("v%0d wb_wr", i), wb_wr, tbl[i].ww);
            check($sformatf("v%0d err_stall", i), err_stall, tbl[i].err);
            check($sformatf("v%0d stall_cnt", i), 32'(stall_cnt), tbl[i].sc);
            check($sformatf("v%0d bubble_cnt", i), 32'(bubble_cnt), tbl[i].bc);
        end

        // Stall with a non-load in EX: sticky error until reset.
        do_reset();
        drive(1'b1, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 4'd3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        check("nonload stall err", err_stall, 1);
        drive(1'b1, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) tick();
        check("err sticky", err_stall, 1);
        rst_n = 1'b0;
        #1;
        check("err cleared by reset", err_stall, 0);

        // Stall held for two cycles after a load.
        do_reset();
        drive(1'b1, 4'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 4'd4, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        check("first stall legal", err_stall, 0);
        tick();
        check("second stall err", err_stall, 1);

        // Counter saturation at 3 bits.
        do_reset();
        drive(1'b1, 4'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 4'd4, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 10; k++) begin
            tick();
            check($sformatf("sat stall_cnt %0d", k), 32'(stall_cnt), (k + 1 > 7) ? 7 : k + 1);
            check($sformatf("sat bubble_cnt %0d", k), 32'(bubble_cnt), (k + 1 > 7) ? 7 : k + 1);
        end

        // Async reset between edges with a pending flush and an active stall.
        do_reset();
        drive(1'b1, 4'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 4'd4, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b1, 4'd4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        drive(1'b1, 4'd4, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        #2;
        check("pre-arst mem_dst", mem_dst, 2);
        rst_n = 1'b0;
        #1;
        check("arst stages", {ex_dst, ex_wr, ex_load, mem_dst, mem_wr, wb_dst, wb_wr}, 0);
        check("arst counters", {stall_cnt, bubble_cnt}, 0);
        check("arst err", err_stall, 0);
        drive(1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        rst_n = 1'b1;
        drive(1'b1, 4'd6, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        check("no flush survives", {ex_dst, ex_wr, ex_load}, {4'd6, 1'b1, 1'b1});
        check("post-arst bubble_cnt", 32'(bubble_cnt), 0);
        drive(1'b1, 4'd5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        check("run after arst err", err_stall, 0);
        check("run after arst stall_cnt", 32'(stall_cnt), 1);
        drive(1'b1, 4'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        check("run after arst ex_dst", ex_dst, 5);
        check("run after arst err2", err_stall, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
